// File: rtl/shift_left_seq.sv
// ============================================================================
// shift_left_seq
// ----------------------------------------------------------------------------
// Iterative logical left shifter for the SLL/SLLV path of the multi-cycle
// MIPS datapath. The block shifts the operand by one bit position per clock
// and reports completion with a single-cycle done pulse. The multi-cycle
// controller holds the instruction until done is seen.
//
// Optional feature macro: SHL_OVF_EN
//   defined   : a sticky signed-overflow flag is built. The flag is set when
//               the shifted result differs from signed tg * 2^sh.
//   undefined : no overflow logic is built and ovf is tied to 0.
//
// Parameters
//   WIDTH  operand/result width (32 for the MIPS datapath)
//   SHW    shift-amount width, must equal $clog2(WIDTH)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request, sampled only while idle
//   tg     in   WIDTH  operand, captured on the accepted start edge
//   sh     in   SHW    shift amount (0..WIDTH-1), captured with tg
//   busy   out  1      high while a shift is in progress
//   done   out  1      one-cycle completion pulse
//   res    out  WIDTH  result, held until the next completion
//   ovf    out  1      signed-overflow flag, valid with done, held with res
//
// Timing: the accepted start edge is edge 0. Edges 1..sh each shift once,
// and edge sh+1 publishes res/ovf and raises done. The done cycle is an idle
// cycle, so a new start can be accepted in it (back-to-back issue).
// ============================================================================
module shift_left_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tg,
    input  logic [SHW-1:0]   sh,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    // Two-state sequencer: waiting for a request, or shifting.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [SHW-1:0]   cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] res_r;

    // Zero-fill constants for literals sized by parameter.
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [SHW-1:0]   ZERO_S = {SHW{1'b0}};
    localparam logic [SHW-1:0]   ONE_S  = {{(SHW-1){1'b0}}, 1'b1};

    // Decoded in-flight conditions, shared by the main sequencer and the
    // optional overflow tracker so both act on exactly the same edges.
    logic accept_s;
    logic shift_s;
    logic finish_s;

    // Decode which action the current edge will take.
    always_comb begin
        accept_s = 1'b0;
        shift_s  = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cnt_r != ZERO_S) begin
                    shift_s = 1'b1;
                end else begin
                    finish_s = 1'b1;
                end
            end
            default: begin
                accept_s = 1'b0;
                shift_s  = 1'b0;
                finish_s = 1'b0;
            end
        endcase
    end

    // Main sequencer: captures operands, shifts one bit per cycle and
    // publishes the result with a single-cycle done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= ZERO_W;
            cnt_r   <= ZERO_S;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            res_r   <= ZERO_W;
        end else begin
            // done is a pulse: cleared on every edge that does not set it.
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        // A zero shift amount still passes through SHIFT so
                        // that latency is uniformly sh+1.
                        acc_r   <= tg;
                        cnt_r   <= sh;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (shift_s) begin
                        // Zero fill at the LSB; the MSB falls off the top.
                        acc_r   <= {acc_r[WIDTH-2:0], 1'b0};
                        cnt_r   <= cnt_r - ONE_S;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        res_r   <= acc_r;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SHL_OVF_EN
    logic ovf_acc_r;
    logic ovf_r;

    // Sticky overflow tracker: a shift changes the signed value whenever the
    // two top bits differ just before it, because the sign bit would change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_acc_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                ovf_acc_r <= 1'b0;
            end else if (shift_s) begin
                if (acc_r[WIDTH-1] != acc_r[WIDTH-2]) begin
                    ovf_acc_r <= 1'b1;
                end else begin
                    ovf_acc_r <= ovf_acc_r;
                end
            end else if (finish_s) begin
                ovf_r <= ovf_acc_r;
            end else begin
                ovf_acc_r <= ovf_acc_r;
            end
        end
    end

    assign ovf = ovf_r;
`else
    // Overflow reporting not built: flag permanently clear.
    assign ovf = 1'b0;
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign res  = res_r;

endmodule

// File: tb/tb_shift_left_seq.sv
module tb_shift_left_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] tg;
    logic [4:0]  sh;
    logic        busy;
    logic        done;
    logic [31:0] res;
    logic        ovf;

    int total;
    int bad;

    shift_left_seq #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .tg    (tg),
        .sh    (sh),
        .busy  (busy),
        .done  (done),
        .res   (res),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: result is the operand times 2^sh, truncated.
    function automatic logic [31:0] model_res(input logic [31:0] t, input int s);
        longint unsigned p;
        p = longint'(t) * (64'd1 << s);
        return p[31:0];
    endfunction

    // Overflow: truncated result, read as signed, differs from signed t*2^s.
    function automatic logic model_ovf(input logic [31:0] t, input int s);
`ifdef SHL_OVF_EN
        longint p;
        logic [31:0] r;
        p = longint'($signed(t)) * (64'sd1 <<< s);
        r = model_res(t, s);
        return (p != longint'($signed(r)));
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an accepted start; afterwards scramble inputs to show they are
    // not resampled. Leaves the bench 1 time unit after edge 0.
    task automatic issue(input logic [31:0] t, input logic [4:0] s);
        start = 1'b1;
        tg    = t;
        sh    = s;
        tick();
        start = 1'b0;
        tg    = $urandom;
        sh    = 5'($urandom);
    endtask

    // Wait for done (bounded), then check latency, result, flag and busy.
    // 'elapsed' is the number of edges already consumed since edge 0.
    task automatic wait_check(input string tag, input logic [31:0] t, input int s, input int elapsed);
        int n;
        n = elapsed;
        while (!done && n < 40) begin
            chk({tag, ".busy_run"}, 32'(busy), 32'd1);
            tick();
            n++;
        end
        chk({tag, ".done_seen"}, 32'(done), 32'd1);
        chk({tag, ".latency"}, 32'(n), 32'(s + 1));
        chk({tag, ".res"}, res, model_res(t, s));
        chk({tag, ".ovf"}, 32'(ovf), 32'(model_ovf(t, s)));
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    endtask

    // One cycle after done: pulse gone, outputs held.
    task automatic after_done(input string tag, input logic [31:0] t, input int s);
        tick();
        chk({tag, ".done_clr"}, 32'(done), 32'd0);
        chk({tag, ".res_hold"}, res, model_res(t, s));
        chk({tag, ".ovf_hold"}, 32'(ovf), 32'(model_ovf(t, s)));
    endtask

    initial begin
        logic [31:0] rt;
        int          rs;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        tg    = 32'hA5A5A5A5;
        sh    = 5'd7;

        // Reset state
        tick();
        tick();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.res", res, 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic shift
        issue(32'h000000F0, 5'd4);
        wait_check("basic", 32'h000000F0, 4, 0);
        chk("basic.const", res, 32'h00000F00);
        after_done("basic", 32'h000000F0, 4);

        // Zero shift
        issue(32'h12345678, 5'd0);
        wait_check("zero", 32'h12345678, 0, 0);
        chk("zero.const", res, 32'h12345678);
        after_done("zero", 32'h12345678, 0);

        // Full-width shift
        issue(32'hFFFFFFFF, 5'd31);
        wait_check("full", 32'hFFFFFFFF, 31, 0);
        chk("full.const", res, 32'h80000000);
        after_done("full", 32'hFFFFFFFF, 31);

        // Overflow case
        issue(32'h80000001, 5'd1);
        wait_check("ovf1", 32'h80000001, 1, 0);
        chk("ovf1.const", res, 32'h00000002);
`ifdef SHL_OVF_EN
        chk("ovf1.flag", 32'(ovf), 32'd1);
`else
        chk("ovf1.flag", 32'(ovf), 32'd0);
`endif
        after_done("ovf1", 32'h80000001, 1);

        // Busy start ignored, then back-to-back start in the done cycle
        issue(32'h00000001, 5'd3);
        tick();
        start = 1'b1;
        tg    = 32'hDEADBEEF;
        sh    = 5'd5;
        tick();
        start = 1'b0;
        wait_check("busyign", 32'h00000001, 3, 2);
        chk("busyign.const", res, 32'h00000008);
        issue(32'h00000003, 5'd1);
        chk("b2b.done_clr", 32'(done), 32'd0);
        wait_check("b2b", 32'h00000003, 1, 0);
        chk("b2b.const", res, 32'h00000006);
        after_done("b2b", 32'h00000003, 1);

        // Reset mid-operation
        issue(32'h0000FFFF, 5'd20);
        for (int i = 0; i < 4; i++) tick();
        chk("abort.busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.res", res, 32'd0);
        chk("abort.ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 25; i++) begin
            tick();
            chk("abort.no_done", 32'(done), 32'd0);
        end
        issue(32'h0000FFFF, 5'd2);
        wait_check("postrst", 32'h0000FFFF, 2, 0);
        chk("postrst.const", res, 32'h0003FFFC);
        after_done("postrst", 32'h0000FFFF, 2);

        // Randomized operations against the model
        for (int k = 0; k < 24; k++) begin
            rt = $urandom;
            rs = int'($urandom_range(31, 0));
            if (k % 4 == 0) rt = {rt[31], rt[31], rt[29:0]};
            issue(rt, 5'(rs));
            wait_check("rand", rt, rs, 0);
            if (k % 2 == 0) after_done("rand", rt, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_left_seq.md
# shift_left_seq

Iterative, multi-cycle logical left shifter for the MIPS datapath's SLL/SLLV path. It is the left-direction counterpart of the existing right shifters. It accepts a 32-bit operand and a 5-bit shift amount with a start pulse, shifts one bit position per cycle, and returns the result with a one-cycle done pulse. It sits beside the ALU and is sequenced by the multi-cycle controller, which holds the instruction until done.

## Interface
- WIDTH, 32: operand/result width.
- SHW, 5: shift-amount width; must equal $clog2(WIDTH).
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- tg  input  WIDTH  operand, captured on the accepted start edge.
- sh  input  SHW  shift amount (0..WIDTH-1), captured with tg.
- busy  output  1  high while state is SHIFT.
- done  output  1  one-cycle completion pulse.
- res  output  WIDTH  result; holds its value until the next completion.
- ovf  output  1  signed-overflow flag, valid with done and held with res.

## Operation
- Reset (rst_n=0 at a rising edge) forces state to IDLE and sets busy=0, done=0, res=0, ovf=0, and the internal accumulator and counter to 0.
- IDLE, start=1:
  - acc<=tg, cnt<=sh, ovf_acc<=0.
  - State goes to SHIFT; this applies even when sh=0.
- SHIFT, cnt!=0:
  - acc<={acc[WIDTH-2:0],1'b0} (zero fill at the LSB; the MSB is discarded).
  - cnt<=cnt-1.
- SHIFT, cnt==0:
  - res<=acc, ovf<=ovf_acc, done<=1.
  - State goes to IDLE.
- done is cleared on every edge where it is not being set.
- Result equals (tg << sh) truncated to WIDTH. No sign or zero extension is needed at the top.
- start while busy=1 is ignored. It is not queued and tg/sh are not resampled.
- The done cycle is an IDLE cycle, so a start asserted during the done cycle is accepted (back-to-back operation).
- Input changes on tg/sh after the accepted edge have no effect on the operation in flight.
- Reset during SHIFT aborts the operation with no done pulse. res returns to 0.

## Timing
- The accepted start edge is edge 0.
- Edges 1..sh each perform one shift.
- done=1 and res/ovf update at edge sh+1. Latency is sh+1 cycles: 1 cycle for sh=0, 32 cycles for sh=31.
- busy=1 from edge 0 up to edge sh+1, exclusive; it is low in the done cycle.
- Minimum issue interval is sh+2 cycles: sh+1 cycles of latency plus the done cycle, which can carry the next start.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SHL_OVF_EN defined:
  - Before each shift, if acc[WIDTH-1]!=acc[WIDTH-2], set sticky ovf_acc.
  - ovf therefore reports that the result differs from signed tg*2^sh.
- SHL_OVF_EN undefined:
  - ovf logic is not built and the ovf port is tied to 0.
  - All other behaviour and timing is identical.

## Test plan
- Basic shift: tg=0x000000F0, sh=4, start -> done exactly 5 cycles after the start edge, res=0x00000F00, ovf=0.
- Zero shift: tg=0x12345678, sh=0 -> done 1 cycle after start, res=0x12345678, busy never high in the done cycle.
- Full-width shift: tg=0xFFFFFFFF, sh=31 -> done after 32 cycles, res=0x80000000, ovf=0. With tg=0x80000001, sh=1 -> res=0x00000002, ovf=1 (0 without SHL_OVF_EN).
- Busy and back-to-back:
  - Start tg=0x00000001, sh=3.
  - Pulse start with tg=0xDEADBEEF on cycle 2 -> ignored; res=0x00000008.
  - A start in the done cycle with tg=0x00000003, sh=1 -> res=0x00000006 two cycles later.
- Reset mid-operation: start tg=0x0000FFFF, sh=20, assert rst_n=0 at cycle 5 -> busy=0, done stays 0, res=0. A new start afterward with sh=2 completes normally.
